// File: rtl/seg_serial_ctrl_pkg.sv
// Shared definitions for the serial seven-segment display controller:
// glyph table, blank byte, FSM state type and the per-digit byte builder.
package seg_serial_ctrl_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} shapes for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } seg_state_e;

  // Blank wins over everything, including the decimal point.
  function automatic logic [7:0] seg_byte(input logic [6:0] glyph,
                                          input logic       pt,
                                          input logic       blank_digit);
    return blank_digit ? SEG_BLANK : {~pt, glyph};
  endfunction

endpackage

// File: rtl/seg_serial_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
  import seg_serial_ctrl_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_GLYPH[i_hex];
  end

endmodule

// File: rtl/seg_serial_ctrl.sv
// Shifts encoded digit bytes into a cascaded 74HC595-style chain on a divided
// serial clock, then strobes the common output latch.
module seg_serial_ctrl
  import seg_serial_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  done,
  output logic                  seg_clk,
  output logic                  seg_dat,
  output logic                  seg_clrn,
  output logic                  seg_latch
);

  localparam int unsigned NBITS = 8 * DIGITS;
  localparam int unsigned CW    = $clog2(NBITS + 1);
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  seg_state_e       r_state;
  logic [NBITS-1:0] r_sr;
  logic [CW-1:0]    r_bit;
  logic [DW-1:0]    r_div;
  logic             r_busy;
  logic             r_done;
  logic             r_clk;
  logic             r_dat;
  logic             r_clrn;
  logic             r_latch;

  logic [NBITS-1:0] w_load;
  logic             w_div_end;

  // Digit DIGITS-1 occupies the top byte so it leaves the register first.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [6:0] w_glyph;

    hex_to_seg7 u_glyph (
      .i_hex (hex[4*gi +: 4]),
      .o_seg (w_glyph)
    );

    assign w_load[8*gi +: 8] = seg_byte(w_glyph, point[gi], blank[gi]);
  end

  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clk   <= 1'b0;
      r_dat   <= 1'b0;
      r_clrn  <= 1'b0;
      r_latch <= 1'b0;
    end else begin
      r_clrn <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= w_load;
            r_bit   <= '0;
            r_div   <= '0;
            r_busy  <= 1'b1;
            r_clk   <= 1'b0;
            r_dat   <= w_load[NBITS-1];
            r_state <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_clk   <= 1'b1;
            r_state <= SHIFT_HI;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (w_div_end) begin
            r_div <= '0;
            r_clk <= 1'b0;
            r_sr  <= r_sr << 1;
            r_bit <= r_bit + 1'b1;
            // Data for the next bit is presented together with the falling
            // serial clock, giving DIV cycles of setup before the next rise.
            if (r_bit == LAST_BIT) begin
              r_dat   <= 1'b0;
              r_latch <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_dat   <= r_sr[NBITS-2];
              r_state <= SHIFT_LO;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        LATCH: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign seg_clk   = r_clk;
  assign seg_dat   = r_dat;
  assign seg_clrn  = r_clrn;
  assign seg_latch = r_latch;

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Scoreboard bench: the driver queues expected frames, a negedge monitor
// reassembles the serial stream and latch/done timing per DUT instance.
module tb_seg_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start, busy, done, sclk, sdat, clrn, latch;
  logic [31:0] hex0;
  logic [7:0]  pt0, bl0;
  logic [15:0] hex1;
  logic [3:0]  pt1, bl1;

  seg_serial_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .hex(hex0), .point(pt0),
    .blank(bl0), .busy(busy[0]), .done(done[0]), .seg_clk(sclk[0]),
    .seg_dat(sdat[0]), .seg_clrn(clrn[0]), .seg_latch(latch[0])
  );

  seg_serial_ctrl #(.DIGITS(4), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .hex(hex1), .point(pt1),
    .blank(bl1), .busy(busy[1]), .done(done[1]), .seg_clk(sclk[1]),
    .seg_dat(sdat[1]), .seg_clrn(clrn[1]), .seg_latch(latch[1])
  );

  typedef struct {
    int          unit;
    longint      e0;
    logic [63:0] exp;
  } frame_t;

  frame_t q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc++;

  function automatic int digs(input int u);
    return (u == 0) ? 8 : 4;
  endfunction

  function automatic int divv(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference glyphs described by which segments are lit.
  string GL[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] model_byte(input logic [3:0] h, input logic p, input logic b);
    logic [7:0] r;
    string      s;
    r = 8'hFF;
    if (b) return r;
    s = GL[h];
    for (int j = 0; j < s.len(); j++) r[int'(s[j]) - 97] = 1'b0;
    r[7] = ~p;
    return r;
  endfunction

  function automatic logic [63:0] model_frame(input int u, input logic [31:0] h,
                                              input logic [7:0] p, input logic [7:0] b);
    logic [63:0] f;
    f = '0;
    for (int d = digs(u) - 1; d >= 0; d--)
      f = (f << 8) | 64'(model_byte(h[4*d +: 4], p[d], b[d]));
    return f;
  endfunction

  // ---------------- monitor ----------------
  bit          act[2];
  longint      e0m[2], lat_t[2], lastchg[2];
  int          nb[2], terr[2], herr[2], lat_n[2];
  logic [63:0] st[2];
  logic [1:0]  pclk = '0, pdat = '0, pbusy = '0, platch = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) act[u] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (busy[u] && !pbusy[u]) begin
          if (q.size() == 0 || q[0].unit != u) begin
            check($sformatf("unexpected_frame_u%0d", u), 64'd1, 64'd0);
          end else begin
            check($sformatf("frame_start_u%0d", u), 64'(cyc), 64'(q[0].e0));
            act[u] = 1'b1; e0m[u] = q[0].e0; nb[u] = 0; st[u] = '0;
            terr[u] = 0; herr[u] = 0; lat_t[u] = -1; lat_n[u] = 0;
          end
        end
        if (sdat[u] !== pdat[u]) begin
          if (sclk[u] && act[u]) herr[u]++;
          lastchg[u] = cyc;
        end
        if (sclk[u] && !pclk[u]) begin
          if (!act[u]) begin
            check($sformatf("stray_seg_clk_u%0d", u), 64'd1, 64'd0);
          end else begin
            if (cyc != e0m[u] + 2 * divv(u) * nb[u] + divv(u)) terr[u]++;
            if (cyc - lastchg[u] < divv(u)) terr[u]++;
            st[u] = {st[u][62:0], sdat[u]};
            nb[u]++;
          end
        end
        if (latch[u]) begin
          if (!act[u]) check($sformatf("spurious_latch_u%0d", u), 64'd1, 64'd0);
          else begin
            if (!platch[u]) lat_t[u] = cyc;
            lat_n[u]++;
          end
        end
        if (done[u]) begin
          if (!act[u]) begin
            check($sformatf("spurious_done_u%0d", u), 64'd1, 64'd0);
          end else begin
            frame_t f;
            longint lat;
            f   = q.pop_front();
            lat = 16 * digs(u) * divv(u);
            check($sformatf("stream_u%0d", u), st[u], f.exp);
            check($sformatf("bit_count_u%0d", u), 64'(nb[u]), 64'(8 * digs(u)));
            check($sformatf("sclk_timing_errs_u%0d", u), 64'(terr[u]), 64'd0);
            check($sformatf("dat_hold_errs_u%0d", u), 64'(herr[u]), 64'd0);
            check($sformatf("latch_time_u%0d", u), 64'(lat_t[u]), 64'(f.e0 + lat));
            check($sformatf("latch_width_u%0d", u), 64'(lat_n[u]), 64'(divv(u)));
            check($sformatf("done_time_u%0d", u), 64'(cyc), 64'(f.e0 + lat + divv(u)));
            check($sformatf("busy_at_done_u%0d", u), 64'(busy[u]), 64'd0);
            act[u] = 1'b0;
          end
        end
      end
    end
    pclk = sclk; pdat = sdat; pbusy = busy; platch = latch;
  end

  // ---------------- driver ----------------
  task automatic drive(input int u, input logic [31:0] h, input logic [7:0] p,
                       input logic [7:0] b, input logic s);
    if (u == 0) begin hex0 = h; pt0 = p; bl0 = b; end
    else begin hex1 = h[15:0]; pt1 = p[3:0]; bl1 = b[3:0]; end
    start[u] = s;
  endtask

  // Returns at the negedge following the accepting edge (cyc == E0).
  task automatic launch(input int u, input logic [31:0] h, input logic [7:0] p,
                        input logic [7:0] b, input logic [63:0] exp);
    frame_t f;
    @(negedge clk);
    drive(u, h, p, b, 1'b1);
    f.unit = u; f.e0 = cyc + 1; f.exp = exp;
    q.push_back(f);
    @(negedge clk);
    drive(u, $urandom, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic launch_rand(input int u);
    logic [31:0] h;
    logic [7:0]  p, b;
    h = $urandom; p = 8'($urandom); b = 8'($urandom & $urandom & $urandom);
    launch(u, h, p, b, model_frame(u, h, p, b));
  endtask

  task automatic wait_done(input int u);
    int k;
    for (k = 0; k < 2000 && !done[u]; k++) @(negedge clk);
    check($sformatf("done_seen_u%0d", u), 64'(done[u]), 64'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  initial begin
    longint e0;
    int     dcnt, lcnt;
    logic   pl;

    rst_n = 1'b0;
    start = '0;
    drive(0, '0, '0, '0, 1'b0);
    drive(1, '0, '0, '0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(0, $urandom, 8'($urandom), 8'($urandom), 1'($urandom));
      drive(1, $urandom, 8'($urandom), 8'($urandom), 1'($urandom));
      #1 check("reset_outputs", 64'({busy, done, sclk, sdat, latch, clrn}), 64'd0);
    end
    @(negedge clk);
    start = '0;
    #2 rst_n = 1'b1;
    #1 check("clrn_before_edge", 64'(clrn), 64'd0);
    @(negedge clk);
    check("clrn_after_release", 64'(clrn), 64'd3);

    launch(0, 32'h0000_0000, 8'h00, 8'h00, 64'hC0C0_C0C0_C0C0_C0C0);
    wait_done(0);
    launch(0, 32'h0123_89AF, 8'h01, 8'h80, 64'hFFF9_A4B0_8090_880E);
    wait_done(0);

    // Starts during the shift phase and during the DONE cycle must be dropped.
    launch_rand(0);
    e0 = cyc; dcnt = 0; lcnt = 0; pl = 1'b0;
    while (cyc < e0 + 275) begin
      start[0] = (cyc == e0 + 9) || (cyc == e0 + 258);
      if (done[0]) dcnt++;
      if (latch[0] && !pl) lcnt++;
      pl = latch[0];
      @(negedge clk);
    end
    start[0] = 1'b0;
    check("single_done", 64'(dcnt), 64'd1);
    check("single_latch", 64'(lcnt), 64'd1);

    // Reset mid-transfer: outputs drop at once and the frame is abandoned.
    launch_rand(0);
    e0 = cyc;
    while (cyc < e0 + 100) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("midreset_outputs",
             64'({busy[0], done[0], sclk[0], sdat[0], latch[0], clrn[0]}), 64'd0);
    q.delete();
    repeat (3) @(negedge clk);
    check("midreset_no_latch", 64'(latch), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    launch_rand(0);
    wait_done(0);

    repeat (5) begin
      launch_rand(0);
      wait_done(0);
    end

    launch(1, 32'h0000_89AF, 8'h02, 8'h00, model_frame(1, 32'h0000_89AF, 8'h02, 8'h00));
    wait_done(1);
    repeat (8) begin
      launch_rand(1);
      wait_done(1);
    end

    repeat (20) @(negedge clk);
    check("leftover_frames", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (compared %0d, mismatched %0d)",
             n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
